// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated 8-bit ALU front end.
// Opcodes, FSM states and the flag bundle live here.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with a 9-bit internal result.
// Bit 8 of the wide result carries the opcode-specific carry flag.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result,
  output flags_t     flags
);

  logic [8:0] wide;

  // SUB borrows into bit 8 when a < b; NOT forces carry high.
  always_comb begin
    wide = 9'd0;
    case (op)
      ALU_ADD: wide = {1'b0, a} + {1'b0, b};
      ALU_SUB: wide = {1'b0, a} - {1'b0, b};
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_NOT: wide = {1'b1, ~a};
      ALU_SHL: wide = {a, 1'b0};
      ALU_SHR: wide = {2'b00, a[7:1]};
      default: wide = 9'd0;
    endcase
  end

  assign result         = wide[7:0];
  assign flags.zero     = (wide[7:0] == 8'd0);
  assign flags.carry    = wide[8];
  assign flags.negative = wide[7];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared ALU.
// One op in flight: IDLE accepts, EXEC computes, RESP returns.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_negative,
  output logic       busy
);

  state_t     state;
  state_t     state_nx;
  logic       prio;
  logic       owner;
  logic       gnt;
  logic       take;
  logic       rsp_hs;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic [7:0] res_q;
  flags_t     flg_q;
  logic [7:0] alu_res;
  flags_t     alu_flg;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  always_comb begin
    gnt = prio;
    unique case (1'b1)
      (req_valid == 2'b01): gnt = 1'b0;
      (req_valid == 2'b10): gnt = 1'b1;
      default:              gnt = prio;
    endcase
  end

  // req_ready is held low while reset is asserted.
  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    take      = 1'b0;
    rsp_hs    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|req_valid) && !rst) begin
          take           = 1'b1;
          req_ready[gnt] = 1'b1;
          state_nx       = ST_EXEC;
        end
      end
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_hs   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio  <= INIT_PRIO;
      owner <= 1'b0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      op_q  <= 3'd0;
      res_q <= 8'd0;
      flg_q <= '0;
    end else begin
      if (take) begin
        owner <= gnt;
        a_q   <= gnt ? req1_a  : req0_a;
        b_q   <= gnt ? req1_b  : req0_b;
        op_q  <= gnt ? req1_op : req0_op;
      end
      if (state == ST_EXEC) begin
        res_q <= alu_res;
        flg_q <= alu_flg;
      end
      if (rsp_hs) prio <= ~owner;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign rsp_result   = res_q;
  assign rsp_zero     = flg_q.zero;
  assign rsp_carry    = flg_q.carry;
  assign rsp_negative = flg_q.negative;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter.
// A transaction-level model is compared against the DUT every cycle.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req0_a = 8'd0;
  logic [7:0] req0_b = 8'd0;
  logic [2:0] req0_op = 3'd0;
  logic [7:0] req1_a = 8'd0;
  logic [7:0] req1_b = 8'd0;
  logic [2:0] req1_op = 3'd0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_negative;
  logic       busy;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_negative (rsp_negative),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic: {result, z, c, n}.
  function automatic logic [10:0] ref_alu(input int a, input int b,
                                          input int op);
    int r;
    int c;
    logic [7:0] r8;
    r = 0;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = 255 - a; c = 1; end
      6: begin r = a * 2; c = (a >= 128) ? 1 : 0; end
      default: r = a / 2;
    endcase
    r  = r & 255;
    r8 = r[7:0];
    return {r8, (r == 0), (c != 0), (r >= 128)};
  endfunction

  // Model: one op in flight; response shows from the second cycle on.
  bit          m_busy = 0;
  bit          m_owner = 0;
  bit          m_prio = 0;
  int          m_cnt = 0;
  logic [10:0] m_exp = '0;
  logic [1:0]  er;
  logic [1:0]  ev;
  logic [1:0]  hs_seen = 2'b00;

  always @(negedge clk) begin
    if (rst) begin
      m_busy  = 0;
      m_prio  = 0;
      m_cnt   = 0;
      hs_seen = 2'b00;
    end else begin
      er = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b11) er = m_prio ? 2'b10 : 2'b01;
        else                    er = req_valid;
      end
      ev = 2'b00;
      if (m_busy && m_cnt >= 1) ev = m_owner ? 2'b10 : 2'b01;
      chk("m_req_ready", int'(req_ready), int'(er));
      chk("m_rsp_valid", int'(rsp_valid), int'(ev));
      chk("m_busy", int'(busy), int'(m_busy));
      if (ev != 2'b00) begin
        chk("m_result", int'(rsp_result), int'(m_exp[10:3]));
        chk("m_zero", int'(rsp_zero), int'(m_exp[2]));
        chk("m_carry", int'(rsp_carry), int'(m_exp[1]));
        chk("m_neg", int'(rsp_negative), int'(m_exp[0]));
      end
      hs_seen = req_valid & req_ready;
      if (!m_busy) begin
        if (er != 2'b00) begin
          m_busy  = 1;
          m_owner = er[1];
          m_cnt   = 0;
          if (er[1]) m_exp = ref_alu(int'(req1_a), int'(req1_b),
                                     int'(req1_op));
          else       m_exp = ref_alu(int'(req0_a), int'(req0_b),
                                     int'(req0_op));
        end
      end else if (m_cnt >= 1 && rsp_ready[m_owner]) begin
        m_busy = 0;
        m_prio = !m_owner;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
    if (i == 0) begin
      req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 60);
    chk("idle_timeout", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input int i, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 60);
    chk(name, int'(req_ready[i]), 1);
  endtask

  task automatic do_op(input int i, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] er8, input logic ez,
                       input logic ec, input logic en,
                       input string name);
    int n;
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    wait_accept(i, {name, "_accept"});
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[i] && n < 20);
    chk({name, "_latency"}, n, 2);
    chk({name, "_result"}, int'(rsp_result), int'(er8));
    chk({name, "_zero"}, int'(rsp_zero), int'(ez));
    chk({name, "_carry"}, int'(rsp_carry), int'(ec));
    chk({name, "_neg"}, int'(rsp_negative), int'(en));
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int n;
    logic [1:0] acc;

    // reset values
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(rsp_result), 0);
    chk("rst_flags", int'({rsp_zero, rsp_carry, rsp_negative}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 8'hF0, 8'h20, ALU_ADD, 8'h10, 0, 1, 0, "add");
    do_op(1, 8'h05, 8'h07, ALU_SUB, 8'hFE, 0, 1, 1, "sub_borrow");
    do_op(1, 8'h07, 8'h07, ALU_SUB, 8'h00, 1, 0, 0, "sub_eq");

    // contention: both continuously valid, grants must alternate
    rsp_ready = 2'b11;
    set_req(0, 8'h11, 8'h22, ALU_ADD);
    set_req(1, 8'h33, 8'h0F, ALU_AND);
    req_valid = 2'b11;
    k = 0;
    n = 0;
    while (k < 8 && n < 100) begin
      @(negedge clk);
      n++;
      chk("rdy_onehot", int'(req_ready != 2'b11), 1);
      if (busy) chk("rdy_outside_idle", int'(req_ready), 0);
      if (req_ready != 2'b00) begin
        chk("grant_order", int'(req_ready), (k % 2) ? 2 : 1);
        acc = req_ready;
        k++;
        @(posedge clk); #1;
        if (acc[0]) set_req(0, 8'($urandom), 8'($urandom), 3'((2 * k) % 8));
        if (acc[1]) set_req(1, 8'($urandom), 8'($urandom),
                            3'((2 * k + 1) % 8));
      end
    end
    chk("contention_count", k, 8);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // backpressure on requester 0 while requester 1 waits
    rsp_ready = 2'b00;
    set_req(0, 8'h33, 8'h44, ALU_ADD);
    req_valid = 2'b01;
    wait_accept(0, "bp_accept");
    @(posedge clk); #1;
    set_req(1, 8'h0C, 8'h0A, ALU_XOR);
    req_valid = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 20);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_result", int'(rsp_result), 8'h77);
      chk("bp_flags", int'({rsp_zero, rsp_carry, rsp_negative}), 0);
      chk("bp_req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_grant", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    do_op(0, 8'hFF, 8'h00, ALU_NOT, 8'h00, 1, 1, 0, "not_ff");
    do_op(1, 8'h81, 8'h00, ALU_SHL, 8'h02, 0, 1, 0, "shl_81");
    do_op(0, 8'h01, 8'h00, ALU_SHR, 8'h00, 1, 0, 0, "shr_01");

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || hs_seen[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
        end
      end
      rsp_ready = 2'($urandom);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 60 && req_valid != 2'b00; c++) begin
      rsp_ready = 2'b11;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();

    // reset while a response is presented
    rsp_ready = 2'b00;
    set_req(1, 8'h10, 8'h01, ALU_SUB);
    req_valid = 2'b10;
    wait_accept(1, "rr_accept");
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 20);
    chk("rr_rsp_before", int'(rsp_valid), 2);
    #2 rst = 1'b1;
    #1;
    chk("rr_rsp_drop", int'(rsp_valid), 0);
    chk("rr_busy_drop", int'(busy), 0);
    chk("rr_result_clr", int'(rsp_result), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 8'h01, 8'h02, ALU_ADD);
    set_req(1, 8'h55, 8'hAA, ALU_OR);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rr_init_prio", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 20);
    chk("rr_fresh_lat", n, 2);
    chk("rr_fresh_result", int'(rsp_result), 8'h03);
    wait_accept(1, "rr_req1_accept");
    chk("rr_req1_grant", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
